// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the
// instruction-memory port arbiter.
package imem_pkg;

  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 16;
  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_STARVE = 4;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating loader-starvation counter.
// sat forces the loader ahead of fetch.
module imem_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(MAX));

  // Count fetch wins over a pending loader
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single imem port between fetch and loader.
// Optional IMEM_LOCK_EN adds ld_lock for exclusive loader access.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int DATA_W     = IMEM_DATA_W,
  parameter int DEPTH      = IMEM_DEPTH,
  parameter int STARVE_MAX = IMEM_STARVE,
  localparam int MA_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IMEM_LOCK_EN
  input  logic              ld_lock,
`endif
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  output logic [MA_W-1:0]   mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  imem_state_t     state_q;
  imem_state_t     state_d;
  logic            lock;
  logic            sat;
  logic            if_ok;
  logic            ld_ok;
  logic [MA_W-1:0] addr_q;

`ifdef IMEM_LOCK_EN
  assign lock = ld_lock;
`else
  assign lock = 1'b0;
`endif

  assign if_ok = (if_addr < ADDR_W'(DEPTH));
  assign ld_ok = (ld_addr < ADDR_W'(DEPTH));

  imem_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (if_gnt & ld_req),
    .clr (ld_gnt | ~ld_req | lock),
    .sat (sat)
  );

  // Fetch wins contention unless the loader has starved
  always_comb begin
    if_gnt   = if_req & ~lock & ~(ld_req & sat);
    ld_gnt   = ld_req & ~if_gnt;
    if_stall = if_req & ~if_gnt;
  end

  // Drive the memory port; address holds when idle
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = ld_gnt & ld_we & ld_ok;
    mem_wdata = ld_wdata;
    unique case (1'b1)
      if_gnt:  mem_addr = if_addr[MA_W-1:0];
      ld_gnt:  mem_addr = ld_addr[MA_W-1:0];
      default: mem_addr = addr_q;
    endcase
  end

  // Next state records who owned the port
  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      if_gnt:  state_d = FETCH;
      ld_gnt:  state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // State and held address registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= mem_addr;
    end
  end

  // Capture read return at the grant edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_data  <= '0;
      ld_rdata <= '0;
      ld_err   <= 1'b0;
    end else begin
      if (if_gnt) begin
        if_data <= if_ok ? mem_rdata
                         : DATA_W'(NOP_INSTR);
      end
      if (ld_gnt) begin
        ld_rdata <= (ld_we || !ld_ok) ? '0
                                      : mem_rdata;
      end
      ld_err <= ld_gnt & ~ld_ok;
    end
  end

  assign if_valid = (state_q == FETCH);
  assign ld_valid = (state_q == LOAD);

endmodule
